aes_round_seq: RTL and testbench
================================

AES_ROUND_SEQ -- requirements
Module: aes_round_seq

Interface
REQ-001 Parameter: N, default 128, state/datapath width in bits.
REQ-002 Parameter: NR, default 10, number of rounds; legal values 10, 12 or 14.
REQ-003 Parameter: RW, default 4, round-index width; equals $clog2(NR+1).
REQ-004 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-005 Port: rst  input  1  reset, asynchronous and active-high.
REQ-006 Port: in_valid  input  1  new whitened block is present at the upstream 2:1 mux In1.
REQ-007 Port: in_ready  output  1  block can accept a new input.
REQ-008 Port: mux_sel  output  1  select for the upstream 2:1 mux; 0 = fresh input (In1), 1 = round feedback (In2).
REQ-009 Port: mux_out  input  N  output of the upstream 2:1 mux; the only data input.
REQ-010 Port: state_out  output  N  registered state, drives the external round function.
REQ-011 Port: round_idx  output  RW  index of the round currently being computed; goes to the key schedule.
REQ-012 Port: last_round  output  1  high while the final round (no MixColumns) is computed.
REQ-013 Port: out_valid  output  1  data_out holds a finished block.
REQ-014 Port: out_ready  input  1  downstream accepts data_out.
REQ-015 Port: data_out  output  N  finished block; equals state_out.

Function
REQ-016 The FSM shall have exactly three states: IDLE, RUN and DONE.
REQ-017 IDLE: in_ready=1, mux_sel=0, out_valid=0.
REQ-018 IDLE with in_valid=1: at the edge, state<=mux_out, round_idx<=1, next state RUN.
REQ-019 RUN: in_ready=0, mux_sel=1.
REQ-020 RUN with round_idx=k<NR: at each edge, state<=mux_out and round_idx<=k+1.
REQ-021 RUN with round_idx=NR: at the edge, state<=mux_out and next state DONE; round_idx is held.
REQ-022 last_round shall be 1 iff state is RUN and round_idx==NR.
REQ-023 DONE: out_valid=1, in_ready=0, and mux_sel holds 1; state and round_idx are held.
REQ-024 DONE with out_ready=1: at the edge, next state IDLE and round_idx<=0; state_out is held until the next accept.
REQ-025 Latency: out_valid rises exactly NR cycles after the accept edge (in_valid & in_ready).
REQ-026 Throughput: one block per NR+2 cycles when out_ready is tied high.
REQ-027 in_valid shall be ignored in RUN and DONE; there is never an accept and an output handshake in the same cycle.
REQ-028 In DONE, out_valid shall stay high and data_out stable until out_ready=1 (backpressure for any duration).
REQ-029 round_idx shall never exceed NR and never wraps.
REQ-030 All outputs shall be direct register or state decodes; no combinational path from any input to any output.

Reset
REQ-031 rst=1 shall immediately force state IDLE, state_out=0, round_idx=0, out_valid=0, last_round=0, mux_sel=0 and in_ready=1, independent of clk.
REQ-032 rst asserted mid-RUN or mid-DONE shall abort the block with no out_valid pulse.
REQ-033 The first accept after rst deassertion shall be possible on the first rising edge.

Structure
REQ-034 The shared package aes_pkg shall hold the FSM state encoding (IDLE/RUN/DONE), the constants NR_128=10, NR_192=12 and NR_256=14, and the round-index width function.
REQ-035 One natural sub-module, aes_round_cnt, shall implement the load/increment/hold counter with terminal flag; everything else stays in aes_round_seq.
REQ-036 The round function, key schedule and 2:1 mux shall stay outside this block.

Verification
REQ-037 Bench wraps the block with a stub round function (In2 = state_out + 1) and the 2:1 mux; the bench shall cover the following scenarios.
REQ-038 Basic: mux In1=0, one in_valid pulse, out_ready=1 -> out_valid exactly 10 cycles after accept, data_out=0x...0A, round_idx sequence 1..10.
REQ-039 Backpressure: out_ready=0 for 5 cycles after out_valid -> data_out=0x...0A stable and out_valid high throughout; IDLE and in_ready=1 the cycle after release.
REQ-040 Reset mid-run: assert rst while round_idx=6 -> all outputs zero/IDLE at once, in_ready=1, no out_valid; next block (In1=0x100) -> data_out=0x10A.
REQ-041 Ignored input: in_valid held high across RUN with In1 changing -> result still 0x...0A; back-to-back blocks spaced NR+2 cycles apart.
REQ-042 NR=14: In1=0xFF -> out_valid after 14 cycles, data_out=0x10D, last_round high only while round_idx=14.

Source files
------------

// File: rtl/aes_pkg.sv
// Shared definitions for the AES round sequencer slice.
//   aes_state_e : FSM state encoding (IDLE / RUN / DONE)
//   NR_128/192/256 : round counts for the three AES key sizes
//   aes_rw()    : width of a round index able to hold 0..nr
package aes_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } aes_state_e;

    localparam int NR_128 = 10;
    localparam int NR_192 = 12;
    localparam int NR_256 = 14;

    // Round index must represent 0 (idle) through nr (final round).
    function automatic int aes_rw(input int nr);
        return $clog2(nr + 1);
    endfunction

endpackage

// File: rtl/aes_round_seq_if.sv
// Bus between the round sequencer and its surroundings (upstream 2:1 mux,
// external round function, key schedule and downstream consumer).
//   slave  : the sequencer side
//   master : the environment side (mux, round function, producer/consumer)
// Parameters: N = datapath width, RW = round-index width.
interface aes_round_seq_if #(
    parameter int N  = 128,
    parameter int RW = 4
);
    logic          in_valid;
    logic          in_ready;
    logic          mux_sel;
    logic [N-1:0]  mux_out;
    logic [N-1:0]  state_out;
    logic [RW-1:0] round_idx;
    logic          last_round;
    logic          out_valid;
    logic          out_ready;
    logic [N-1:0]  data_out;

    modport slave (
        input  in_valid, mux_out, out_ready,
        output in_ready, mux_sel, state_out, round_idx, last_round,
               out_valid, data_out
    );

    modport master (
        output in_valid, mux_out, out_ready,
        input  in_ready, mux_sel, state_out, round_idx, last_round,
               out_valid, data_out
    );
endinterface

// File: rtl/aes_round_cnt.sv
// Round counter for the AES sequencer.
// Ports:
//   clk, rst : clock, asynchronous active-high reset (count -> 0)
//   clr      : return to 0 (block handed off)
//   load     : start a new block at round 1
//   inc      : advance one round; saturates at NR so it can never wrap
//   count    : current round index
//   term     : count has reached the final round NR
module aes_round_cnt #(
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          load,
    input  logic          inc,
    output logic [RW-1:0] count,
    output logic          term
);
    logic [RW-1:0] count_reg;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count_reg <= '0;
        end else if (clr) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= RW'(1);
        end else if (inc && (count_reg != RW'(NR))) begin
            count_reg <= count_reg + RW'(1);
        end
    end

    assign count = count_reg;
    assign term  = (count_reg == RW'(NR));

endmodule

// File: rtl/aes_round_seq.sv
// Iterative AES round sequencer. Holds the cipher state register, steers
// the upstream 2:1 mux (fresh block vs. round feedback), supplies the round
// index to the key schedule and hands finished blocks downstream with a
// valid/ready handshake. The round function itself lives outside.
// Ports:
//   clk, rst : clock, asynchronous active-high reset
//   bus      : sequencer side of aes_round_seq_if (see interface)
// All outputs are decodes of registers only; no input reaches an output
// combinationally.
module aes_round_seq
    import aes_pkg::*;
#(
    parameter int N  = 128,
    parameter int NR = 10,
    parameter int RW = 4
) (
    input  logic clk,
    input  logic rst,
    aes_round_seq_if.slave bus
);
    aes_state_e    fsm_reg;
    aes_state_e    fsm_next;
    logic [N-1:0]  data_reg;
    logic          load_state;
    logic          cnt_load;
    logic          cnt_inc;
    logic          cnt_clr;
    logic          cnt_term;
    logic [RW-1:0] round_cnt;

    aes_round_cnt #(
        .NR (NR),
        .RW (RW)
    ) u_cnt (
        .clk   (clk),
        .rst   (rst),
        .clr   (cnt_clr),
        .load  (cnt_load),
        .inc   (cnt_inc),
        .count (round_cnt),
        .term  (cnt_term)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm_reg <= IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    // The state register captures the mux output on the accept edge and on
    // every RUN edge, including the final round; it is frozen in DONE and
    // IDLE so data_out stays valid until the next block is taken.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data_reg <= '0;
        end else if (load_state) begin
            data_reg <= bus.mux_out;
        end
    end

    always_comb begin
        fsm_next   = fsm_reg;
        load_state = 1'b0;
        cnt_load   = 1'b0;
        cnt_inc    = 1'b0;
        cnt_clr    = 1'b0;
        case (fsm_reg)
            IDLE: begin
                if (bus.in_valid) begin
                    load_state = 1'b1;
                    cnt_load   = 1'b1;
                    fsm_next   = RUN;
                end
            end
            RUN: begin
                load_state = 1'b1;
                if (cnt_term) begin
                    fsm_next = DONE;
                end else begin
                    cnt_inc = 1'b1;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    cnt_clr  = 1'b1;
                    fsm_next = IDLE;
                end
            end
            default: begin
                fsm_next = IDLE;
            end
        endcase
    end

    // mux_sel stays at feedback through DONE; only IDLE selects fresh input.
    assign bus.in_ready   = (fsm_reg == IDLE);
    assign bus.mux_sel    = (fsm_reg != IDLE);
    assign bus.out_valid  = (fsm_reg == DONE);
    assign bus.last_round = (fsm_reg == RUN) && cnt_term;
    assign bus.round_idx  = round_cnt;
    assign bus.state_out  = data_reg;
    assign bus.data_out   = data_reg;

endmodule

// File: tb/tb_aes_round_seq.sv
// Directed bench for aes_round_seq: stub round function (state + 1) and
// 2:1 mux around an NR=10 instance (a) and an NR=14 instance (b).
module tb_aes_round_seq;

    localparam int N = 128;

    logic         clk;
    logic         rst;
    logic [N-1:0] in1_a;
    logic [N-1:0] in1_b;
    int           tests;
    int           fails;

    aes_round_seq_if #(.N(N), .RW(4)) bus_a ();
    aes_round_seq_if #(.N(N), .RW(4)) bus_b ();

    // Upstream 2:1 mux with the stub round function on In2.
    assign bus_a.mux_out = bus_a.mux_sel ? (bus_a.state_out + 128'd1) : in1_a;
    assign bus_b.mux_out = bus_b.mux_sel ? (bus_b.state_out + 128'd1) : in1_b;

    aes_round_seq #(.N(N), .NR(10), .RW(4)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    aes_round_seq #(.N(N), .NR(14), .RW(4)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        rst = 1'b1;
        #3;
        tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready got %b want 1", bus_a.in_ready); end
        tests++; if (bus_a.mux_sel !== 1'b0) begin fails++; $display("FAIL reset_mux_sel got %b want 0", bus_a.mux_sel); end
        tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid got %b want 0", bus_a.out_valid); end
        tests++; if (bus_a.last_round !== 1'b0) begin fails++; $display("FAIL reset_last_round got %b want 0", bus_a.last_round); end
        tests++; if (bus_a.round_idx !== 4'd0) begin fails++; $display("FAIL reset_round_idx got %0d want 0", bus_a.round_idx); end
        tests++; if (bus_a.state_out !== 128'd0) begin fails++; $display("FAIL reset_state_out got %h want 0", bus_a.state_out); end
        tests++; if (bus_b.in_ready !== 1'b1) begin fails++; $display("FAIL reset_b_in_ready got %b want 1", bus_b.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        $display("[TB] reset: checked idle outputs under reset");
    endtask

    task automatic test_basic();
        @(negedge clk);
        in1_a = 128'd0;
        bus_a.out_ready = 1'b1;
        bus_a.in_valid = 1'b1;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            tests++; if (bus_a.round_idx !== 4'(k)) begin fails++; $display("FAIL basic_round_idx got %0d want %0d", bus_a.round_idx, k); end
            tests++; if (bus_a.last_round !== (k == 10)) begin fails++; $display("FAIL basic_last_round at %0d got %b want %b", k, bus_a.last_round, (k == 10)); end
            tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid at %0d got %b want 0", k, bus_a.out_valid); end
            tests++; if (bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL basic_run_in_ready at %0d got %b want 0", k, bus_a.in_ready); end
            @(negedge clk);
        end
        tests++; if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL basic_out_valid got %b want 1", bus_a.out_valid); end
        tests++; if (bus_a.data_out !== 128'h0A) begin fails++; $display("FAIL basic_data_out got %h want 0a", bus_a.data_out); end
        tests++; if (bus_a.last_round !== 1'b0) begin fails++; $display("FAIL basic_done_last_round got %b want 0", bus_a.last_round); end
        tests++; if (bus_a.mux_sel !== 1'b1) begin fails++; $display("FAIL basic_done_mux_sel got %b want 1", bus_a.mux_sel); end
        @(negedge clk);
        tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL basic_idle_in_ready got %b want 1", bus_a.in_ready); end
        tests++; if (bus_a.round_idx !== 4'd0) begin fails++; $display("FAIL basic_idle_round_idx got %0d want 0", bus_a.round_idx); end
        tests++; if (bus_a.data_out !== 128'h0A) begin fails++; $display("FAIL basic_idle_data_out got %h want 0a", bus_a.data_out); end
        $display("[TB] basic: in1=0 -> data_out=%h", bus_a.data_out);
    endtask

    task automatic test_backpressure();
        int cyc;
        in1_a = 128'd0;
        bus_a.out_ready = 1'b0;
        bus_a.in_valid = 1'b1;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        cyc = 0;
        while (!bus_a.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        tests++; if (cyc !== 10) begin fails++; $display("FAIL bp_latency got %0d want 10", cyc); end
        for (int i = 0; i < 5; i++) begin
            tests++; if (bus_a.out_valid !== 1'b1) begin fails++; $display("FAIL bp_hold_valid cycle %0d got %b want 1", i, bus_a.out_valid); end
            tests++; if (bus_a.data_out !== 128'h0A) begin fails++; $display("FAIL bp_hold_data cycle %0d got %h want 0a", i, bus_a.data_out); end
            tests++; if (bus_a.in_ready !== 1'b0) begin fails++; $display("FAIL bp_hold_in_ready cycle %0d got %b want 0", i, bus_a.in_ready); end
            @(negedge clk);
        end
        bus_a.out_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL bp_release_in_ready got %b want 1", bus_a.in_ready); end
        tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL bp_release_valid got %b want 0", bus_a.out_valid); end
        tests++; if (bus_a.data_out !== 128'h0A) begin fails++; $display("FAIL bp_release_data got %h want 0a", bus_a.data_out); end
        $display("[TB] backpressure: held 5 cycles, released, data_out=%h", bus_a.data_out);
    endtask

    task automatic test_reset_midrun();
        int cyc;
        in1_a = 128'd0;
        bus_a.in_valid = 1'b1;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        cyc = 0;
        while (bus_a.round_idx != 4'd6 && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        tests++; if (bus_a.round_idx !== 4'd6) begin fails++; $display("FAIL rst_reach_round6 got %0d want 6", bus_a.round_idx); end
        #2 rst = 1'b1;
        #1;
        tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL rst_mid_in_ready got %b want 1", bus_a.in_ready); end
        tests++; if (bus_a.mux_sel !== 1'b0) begin fails++; $display("FAIL rst_mid_mux_sel got %b want 0", bus_a.mux_sel); end
        tests++; if (bus_a.round_idx !== 4'd0) begin fails++; $display("FAIL rst_mid_round_idx got %0d want 0", bus_a.round_idx); end
        tests++; if (bus_a.state_out !== 128'd0) begin fails++; $display("FAIL rst_mid_state_out got %h want 0", bus_a.state_out); end
        tests++; if (bus_a.out_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_out_valid got %b want 0", bus_a.out_valid); end
        @(negedge clk);
        in1_a = 128'h100;
        bus_a.in_valid = 1'b1;
        rst = 1'b0;
        @(negedge clk);
        bus_a.in_valid = 1'b0;
        tests++; if (bus_a.round_idx !== 4'd1) begin fails++; $display("FAIL rst_first_accept_idx got %0d want 1", bus_a.round_idx); end
        tests++; if (bus_a.state_out !== 128'h100) begin fails++; $display("FAIL rst_first_accept_state got %h want 100", bus_a.state_out); end
        cyc = 0;
        while (!bus_a.out_valid && cyc < 40) begin
            @(negedge clk);
            cyc++;
        end
        tests++; if (cyc !== 10) begin fails++; $display("FAIL rst_next_latency got %0d want 10", cyc); end
        tests++; if (bus_a.data_out !== 128'h10A) begin fails++; $display("FAIL rst_next_data got %h want 10a", bus_a.data_out); end
        $display("[TB] reset_midrun: aborted at round 6, next block data_out=%h", bus_a.data_out);
    endtask

    task automatic test_back_to_back();
        logic [N-1:0] exp_q;
        int last_acc;
        int n_acc;
        int n_out;
        int cyc;
        bus_a.out_ready = 1'b1;
        cyc = 0;
        while (!bus_a.in_ready && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        tests++; if (bus_a.in_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle got %b want 1", bus_a.in_ready); end
        exp_q = '0;
        last_acc = -1;
        n_acc = 0;
        n_out = 0;
        bus_a.in_valid = 1'b1;
        for (int c = 0; c < 40; c++) begin
            in1_a = (c == 0) ? 128'd0 : {96'd0, $urandom};
            tests++; if (bus_a.in_ready && bus_a.out_valid) begin fails++; $display("FAIL b2b_overlap cycle %0d in_ready=%b out_valid=%b want not both", c, bus_a.in_ready, bus_a.out_valid); end
            if (bus_a.out_valid) begin
                n_out++;
                tests++; if (bus_a.data_out !== exp_q) begin fails++; $display("FAIL b2b_data cycle %0d got %h want %h", c, bus_a.data_out, exp_q); end
                $display("[TB] b2b: output %0d data_out=%h", n_out, bus_a.data_out);
            end
            if (bus_a.in_ready) begin
                exp_q = in1_a + 128'd10;
                if (last_acc >= 0) begin
                    tests++; if (c - last_acc !== 12) begin fails++; $display("FAIL b2b_spacing got %0d want 12", c - last_acc); end
                end
                last_acc = c;
                n_acc++;
            end
            @(negedge clk);
        end
        bus_a.in_valid = 1'b0;
        tests++; if (n_acc < 3) begin fails++; $display("FAIL b2b_accepts got %0d want >=3", n_acc); end
        tests++; if (n_out < 2) begin fails++; $display("FAIL b2b_outputs got %0d want >=2", n_out); end
    endtask

    task automatic test_nr14();
        @(negedge clk);
        in1_b = 128'hFF;
        bus_b.out_ready = 1'b0;
        bus_b.in_valid = 1'b1;
        @(negedge clk);
        bus_b.in_valid = 1'b0;
        for (int k = 1; k <= 14; k++) begin
            tests++; if (bus_b.round_idx !== 4'(k)) begin fails++; $display("FAIL nr14_round_idx got %0d want %0d", bus_b.round_idx, k); end
            tests++; if (bus_b.last_round !== (k == 14)) begin fails++; $display("FAIL nr14_last_round at %0d got %b want %b", k, bus_b.last_round, (k == 14)); end
            tests++; if (bus_b.out_valid !== 1'b0) begin fails++; $display("FAIL nr14_early_valid at %0d got %b want 0", k, bus_b.out_valid); end
            @(negedge clk);
        end
        tests++; if (bus_b.out_valid !== 1'b1) begin fails++; $display("FAIL nr14_out_valid got %b want 1", bus_b.out_valid); end
        tests++; if (bus_b.data_out !== 128'h10D) begin fails++; $display("FAIL nr14_data_out got %h want 10d", bus_b.data_out); end
        tests++; if (bus_b.round_idx !== 4'd14) begin fails++; $display("FAIL nr14_done_idx got %0d want 14", bus_b.round_idx); end
        tests++; if (bus_b.last_round !== 1'b0) begin fails++; $display("FAIL nr14_done_last_round got %b want 0", bus_b.last_round); end
        bus_b.out_ready = 1'b1;
        @(negedge clk);
        tests++; if (bus_b.in_ready !== 1'b1) begin fails++; $display("FAIL nr14_idle_in_ready got %b want 1", bus_b.in_ready); end
        tests++; if (bus_b.round_idx !== 4'd0) begin fails++; $display("FAIL nr14_idle_idx got %0d want 0", bus_b.round_idx); end
        $display("[TB] nr14: in1=ff -> data_out=%h", bus_b.data_out);
    endtask

    initial begin
        tests = 0;
        fails = 0;
        in1_a = '0;
        in1_b = '0;
        bus_a.in_valid = 1'b0;
        bus_a.out_ready = 1'b1;
        bus_b.in_valid = 1'b0;
        bus_b.out_ready = 1'b1;
        test_reset();
        test_basic();
        test_backpressure();
        test_reset_midrun();
        test_back_to_back();
        test_nr14();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
